sap_1_controller_sequencer: RTL and testbench
=============================================

Name: sap_1_controller_sequencer

Overview:
- Control unit for the SAP-1 datapath. It is the initiator that drives the adder/subtractor's Su/Eu pins and every other load/enable line on the W bus.
- A six-state one-hot ring counter (T1..T6) advances every clock. Control outputs are decoded from the ring state and the 4-bit opcode from the instruction register's upper nibble.
- Implements the fetch cycle plus LDA, ADD, SUB, OUT and HLT.

Parameters:
- OP_LDA, 4'b0000, load-accumulator opcode.
- OP_ADD, 4'b0001, add opcode.
- OP_SUB, 4'b0010, subtract opcode.
- OP_OUT, 4'b1110, output opcode.
- OP_HLT, 4'b1111, halt opcode.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Clr  input  1  reset, synchronous, active-high.
- opcode  input  4  instruction register upper nibble; must be stable from T4 through T6.
- t_state  output  6  one-hot ring state; bit0=T1 ... bit5=T6.
- Cp  output  1  increment program counter.
- Ep  output  1  program counter drives W bus.
- Lm  output  1  load memory address register.
- Ce  output  1  RAM drives W bus.
- Li  output  1  load instruction register.
- Ei  output  1  instruction register operand field drives W bus.
- La  output  1  load accumulator.
- Ea  output  1  accumulator drives W bus.
- Su  output  1  adder/subtractor: 1 = subtract, 0 = add.
- Eu  output  1  adder/subtractor drives W bus.
- Lb  output  1  load register B.
- Lo  output  1  load output register.
- Hlt  output  1  halted indication.

Behaviour:
- Clock and reset: one clock, Clk; reset is synchronous and active-high, Clr. All control outputs are active-high.
- Registered state: t_state (one-hot) and a sticky halted flag. All control outputs are combinational decodes of t_state, halted and opcode.
- Clr=1 at a rising edge: t_state <= 6'b000001 and halted <= 0. Clr takes priority over everything, including mid-instruction and while halted.
- Reset output values (T1, not halted): t_state=000001, Ep=1, Lm=1, all other outputs 0.
- Ring sequence: T1->T2->T3->T4->T5->T6->T1, one state per clock, when not halted. Every instruction takes exactly 6 clocks. There is no early termination.
- Decode per state; signals not listed are 0:
  - T1 (address): Ep, Lm.
  - T2 (increment): Cp.
  - T3 (memory): Ce, Li.
  - T4, LDA/ADD/SUB: Ei, Lm.
  - T4, OUT: Ea, Lo.
  - T4, HLT: Hlt.
  - T5, LDA: Ce, La.
  - T5, ADD/SUB: Ce, Lb.
  - T5, OUT/HLT: none.
  - T6, ADD: La, Eu, with Su=0.
  - T6, SUB: La, Eu, Su.
  - T6, LDA/OUT: none.
- Unknown opcodes (any value not in the parameter set): T4–T6 decode to all-zero (NOP). T1–T3 are unaffected.
- Su is asserted only together with Eu. Outside T6 of SUB, Su=0.
- Halt: at a rising edge with t_state=T4, opcode=OP_HLT and Clr=0:
  - halted <= 1 and t_state holds at T4.
  - While halted: t_state frozen, Hlt=1, all other control outputs 0, opcode changes ignored.
  - Only Clr exits the halted state.
- Bus exclusivity: at most one of Ep, Ce, Ei, Ea, Eu is 1 in any cycle. The bench asserts this continuously.
- Invalid one-hot values are unreachable. If forced, the next edge loads T1.

Test Plan:
- Clr=1 for one edge, then Clr=0 -> t_state=000001, Ep=Lm=1, other outputs 0, Hlt=0. The next 2 edges give T2 (Cp=1 only), then T3 (Ce=Li=1).
- opcode=4'b0001 (ADD), run T1..T6 -> T4: Ei=Lm=1; T5: Ce=Lb=1; T6: La=Eu=1, Su=0. The next edge returns t_state to 000001.
- opcode=4'b0010 (SUB) -> T6: La=Eu=Su=1. opcode=4'b0000 (LDA) -> T5: Ce=La=1, T6: all zero. opcode=4'b1110 (OUT) -> T4: Ea=Lo=1.
- opcode=4'b1111 (HLT) -> at T4, Hlt=1. After 10 further edges: t_state=001000, Hlt=1, all other outputs 0, even with opcode changed to 0001. Clr=1 -> next edge t_state=000001, Hlt=0.
- ADD in progress, Clr=1 while in T5 -> next edge t_state=000001. No La/Eu pulse occurs.
- opcode=4'b0101 (unknown) -> T4–T6 all control outputs 0. The one-hot bus-exclusivity check holds across 100 random-opcode cycles.

Source files
------------

// File: rtl/sap_1_controller_sequencer.sv
// -----------------------------------------------------------------------------
// sap_1_controller_sequencer
//
// Control unit for the SAP-1 datapath. A six-state one-hot ring counter
// (T1..T6) advances on every rising clock edge. The control lines are
// combinational decodes of the ring state, a sticky halted flag and the
// opcode nibble from the instruction register.
//
// Ports:
//   Clk      in   system clock, rising edge
//   Clr      in   synchronous active-high reset (priority over everything)
//   opcode   in   instruction register upper nibble, stable T4..T6
//   t_state  out  one-hot ring state, bit0 = T1 ... bit5 = T6
//   Cp  Ep   out  PC increment / PC drives W bus
//   Lm       out  load memory address register
//   Ce       out  RAM drives W bus
//   Li  Ei   out  load IR / IR operand drives W bus
//   La  Ea   out  load accumulator / accumulator drives W bus
//   Su  Eu   out  subtract select / adder-subtractor drives W bus
//   Lb  Lo   out  load B register / load output register
//   Hlt      out  halted indication
// -----------------------------------------------------------------------------
module sap_1_controller_sequencer #(
    parameter logic [3:0] OP_LDA = 4'b0000,
    parameter logic [3:0] OP_ADD = 4'b0001,
    parameter logic [3:0] OP_SUB = 4'b0010,
    parameter logic [3:0] OP_OUT = 4'b1110,
    parameter logic [3:0] OP_HLT = 4'b1111
) (
    input  logic       Clk,
    input  logic       Clr,
    input  logic [3:0] opcode,
    output logic [5:0] t_state,
    output logic       Cp,
    output logic       Ep,
    output logic       Lm,
    output logic       Ce,
    output logic       Li,
    output logic       Ei,
    output logic       La,
    output logic       Ea,
    output logic       Su,
    output logic       Eu,
    output logic       Lb,
    output logic       Lo,
    output logic       Hlt
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } ring_e;

    ring_e t_state_q, t_state_d;
    logic  halted_q, halted_d;

    // State register
    always_ff @(posedge Clk) begin
        if (Clr) begin
            t_state_q <= T1;
            halted_q  <= 1'b0;
        end else begin
            t_state_q <= t_state_d;
            halted_q  <= halted_d;
        end
    end

    // Next-state logic
    always_comb begin
        t_state_d = T1;
        halted_d  = halted_q;
        if (halted_q) begin
            // Frozen until Clr; opcode is ignored.
            t_state_d = t_state_q;
        end else begin
            case (t_state_q)
                T1: t_state_d = T2;
                T2: t_state_d = T3;
                T3: t_state_d = T4;
                T4: begin
                    if (opcode == OP_HLT) begin
                        // Park in T4 so the frozen state shows where we stopped.
                        t_state_d = T4;
                        halted_d  = 1'b1;
                    end else begin
                        t_state_d = T5;
                    end
                end
                T5: t_state_d = T6;
                T6: t_state_d = T1;
                // A corrupted (non one-hot) ring recovers to T1.
                default: t_state_d = T1;
            endcase
        end
    end

    // Output decode
    always_comb begin
        Cp  = 1'b0;
        Ep  = 1'b0;
        Lm  = 1'b0;
        Ce  = 1'b0;
        Li  = 1'b0;
        Ei  = 1'b0;
        La  = 1'b0;
        Ea  = 1'b0;
        Su  = 1'b0;
        Eu  = 1'b0;
        Lb  = 1'b0;
        Lo  = 1'b0;
        Hlt = 1'b0;
        if (halted_q) begin
            Hlt = 1'b1;
        end else begin
            case (t_state_q)
                T1: begin
                    Ep = 1'b1;
                    Lm = 1'b1;
                end
                T2: begin
                    Cp = 1'b1;
                end
                T3: begin
                    Ce = 1'b1;
                    Li = 1'b1;
                end
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            Ei = 1'b1;
                            Lm = 1'b1;
                        end
                        OP_OUT: begin
                            Ea = 1'b1;
                            Lo = 1'b1;
                        end
                        OP_HLT: begin
                            Hlt = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA: begin
                            Ce = 1'b1;
                            La = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            Ce = 1'b1;
                            Lb = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    case (opcode)
                        OP_ADD: begin
                            La = 1'b1;
                            Eu = 1'b1;
                        end
                        OP_SUB: begin
                            // Su only ever rises together with Eu.
                            La = 1'b1;
                            Eu = 1'b1;
                            Su = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign t_state = t_state_q;

endmodule

// File: tb/tb_sap_1_controller_sequencer.sv
module tb_sap_1_controller_sequencer;

    logic       Clk = 1'b0;
    logic       Clr = 1'b1;
    logic [3:0] opcode = 4'b0000;
    logic [5:0] t_state;
    logic Cp, Ep, Lm, Ce, Li, Ei, La, Ea, Su, Eu, Lb, Lo, Hlt;

    int compared_cnt   = 0;
    int mismatched_cnt = 0;

    // Expected control vector bit positions: {Cp,Ep,Lm,Ce,Li,Ei,La,Ea,Su,Eu,Lb,Lo,Hlt}
    localparam logic [12:0] K_CP  = 13'h1000;
    localparam logic [12:0] K_EP  = 13'h0800;
    localparam logic [12:0] K_LM  = 13'h0400;
    localparam logic [12:0] K_CE  = 13'h0200;
    localparam logic [12:0] K_LI  = 13'h0100;
    localparam logic [12:0] K_EI  = 13'h0080;
    localparam logic [12:0] K_LA  = 13'h0040;
    localparam logic [12:0] K_EA  = 13'h0020;
    localparam logic [12:0] K_SU  = 13'h0010;
    localparam logic [12:0] K_EU  = 13'h0008;
    localparam logic [12:0] K_LB  = 13'h0004;
    localparam logic [12:0] K_LO  = 13'h0002;
    localparam logic [12:0] K_HLT = 13'h0001;
    localparam logic [12:0] K_NONE = 13'h0000;

    localparam logic [5:0] S1 = 6'b000001;
    localparam logic [5:0] S2 = 6'b000010;
    localparam logic [5:0] S3 = 6'b000100;
    localparam logic [5:0] S4 = 6'b001000;
    localparam logic [5:0] S5 = 6'b010000;
    localparam logic [5:0] S6 = 6'b100000;

    sap_1_controller_sequencer dut (
        .Clk(Clk), .Clr(Clr), .opcode(opcode), .t_state(t_state),
        .Cp(Cp), .Ep(Ep), .Lm(Lm), .Ce(Ce), .Li(Li), .Ei(Ei),
        .La(La), .Ea(Ea), .Su(Su), .Eu(Eu), .Lb(Lb), .Lo(Lo), .Hlt(Hlt)
    );

    always #5 Clk = ~Clk;

    function automatic logic [12:0] ctrl_vec();
        return {Cp, Ep, Lm, Ce, Li, Ei, La, Ea, Su, Eu, Lb, Lo, Hlt};
    endfunction

    // Advance one edge, sample 1 time unit later, and check bus exclusivity.
    task automatic tick();
        logic [4:0] drivers;
        @(posedge Clk);
        #1;
        drivers = {Ep, Ce, Ei, Ea, Eu};
        compared_cnt++;
        assert ($countones(drivers) <= 1) else begin
            mismatched_cnt++;
            $error("FAIL bus_excl: drivers {Ep,Ce,Ei,Ea,Eu} observed %b expected at most one set", drivers);
        end
    endtask

    task automatic chk(input string tag, input logic [5:0] exp_t, input logic [12:0] exp_c);
        logic [12:0] obs_c;
        obs_c = ctrl_vec();
        compared_cnt++;
        assert (t_state === exp_t) else begin
            mismatched_cnt++;
            $error("FAIL %s t_state: observed %b expected %b", tag, t_state, exp_t);
        end
        compared_cnt++;
        assert (obs_c === exp_c) else begin
            mismatched_cnt++;
            $error("FAIL %s ctrl: observed %b expected %b", tag, obs_c, exp_c);
        end
        $display("step %-12s t_state=%b ctrl=%b", tag, t_state, obs_c);
    endtask

    initial begin
        logic [5:0] exp_t;

        // Reset
        Clr = 1'b1; opcode = 4'b0000;
        tick();
        Clr = 1'b0;
        chk("reset_T1", S1, K_EP | K_LM);
        tick(); chk("fetch_T2", S2, K_CP);
        tick(); chk("fetch_T3", S3, K_CE | K_LI);

        // ADD
        opcode = 4'b0001;
        tick(); chk("add_T4", S4, K_EI | K_LM);
        tick(); chk("add_T5", S5, K_CE | K_LB);
        tick(); chk("add_T6", S6, K_LA | K_EU);
        tick(); chk("add_wrap", S1, K_EP | K_LM);

        // SUB
        opcode = 4'b0010;
        tick(); tick(); chk("sub_T3", S3, K_CE | K_LI);
        tick(); chk("sub_T4", S4, K_EI | K_LM);
        tick(); chk("sub_T5", S5, K_CE | K_LB);
        tick(); chk("sub_T6", S6, K_LA | K_EU | K_SU);
        tick(); chk("sub_wrap", S1, K_EP | K_LM);

        // LDA
        opcode = 4'b0000;
        tick(); tick(); tick(); chk("lda_T4", S4, K_EI | K_LM);
        tick(); chk("lda_T5", S5, K_CE | K_LA);
        tick(); chk("lda_T6", S6, K_NONE);
        tick();

        // OUT
        opcode = 4'b1110;
        tick(); tick(); tick(); chk("out_T4", S4, K_EA | K_LO);
        tick(); chk("out_T5", S5, K_NONE);
        tick(); chk("out_T6", S6, K_NONE);
        tick();

        // Unknown opcode behaves as NOP after fetch
        opcode = 4'b0101;
        tick(); chk("unk_T2", S2, K_CP);
        tick(); chk("unk_T3", S3, K_CE | K_LI);
        tick(); chk("unk_T4", S4, K_NONE);
        tick(); chk("unk_T5", S5, K_NONE);
        tick(); chk("unk_T6", S6, K_NONE);
        tick(); chk("unk_wrap", S1, K_EP | K_LM);

        // HLT, then opcode change while halted, then Clr
        opcode = 4'b1111;
        tick(); tick(); tick(); chk("hlt_T4", S4, K_HLT);
        tick(); chk("hlt_frozen1", S4, K_HLT);
        opcode = 4'b0001;
        for (int i = 0; i < 9; i++) tick();
        chk("hlt_frozen10", S4, K_HLT);
        Clr = 1'b1;
        tick();
        Clr = 1'b0;
        chk("hlt_clr", S1, K_EP | K_LM);

        // Clr in the middle of ADD (during T5) aborts before T6
        opcode = 4'b0001;
        tick(); tick(); tick(); tick(); chk("abort_T5", S5, K_CE | K_LB);
        Clr = 1'b1;
        tick();
        Clr = 1'b0;
        chk("abort_T1", S1, K_EP | K_LM);
        tick(); chk("abort_T2", S2, K_CP);

        // Random non-halting opcodes: ring keeps rotating, exclusivity holds
        exp_t = S2;
        for (int i = 0; i < 100; i++) begin
            opcode = 4'($urandom_range(0, 14));
            tick();
            exp_t = {exp_t[4:0], exp_t[5]};
            compared_cnt++;
            assert (t_state === exp_t) else begin
                mismatched_cnt++;
                $error("FAIL rand_ring[%0d]: observed %b expected %b", i, t_state, exp_t);
            end
        end
        $display("step rand_done   t_state=%b", t_state);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatched_cnt);
        $finish;
    end

endmodule
